// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, instruction field layout, issue FSM states and opcodes
//
// Purpose: common definitions for the decode/operand-fetch stage and the EX stage.
// Ports: none (package).
package pipe_pkg;

    localparam int DATA_W  = 16;
    localparam int IDX_W   = 5;
    localparam int INSTR_W = 32;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } issue_state_t;

    // Opcodes shared with the EX stage
    localparam logic [5:0] OPC_NOP  = 6'h00;
    localparam logic [5:0] OPC_ADD  = 6'h01;
    localparam logic [5:0] OPC_SUB  = 6'h02;
    localparam logic [5:0] OPC_AND  = 6'h03;
    localparam logic [5:0] OPC_OR   = 6'h04;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_LOAD = 6'h10;
    localparam logic [5:0] OPC_STOR = 6'h11;
    localparam logic [5:0] OPC_BEQ  = 6'h20;

endpackage

// File: rtl/operand_bypass_mux.sv
// rtl/operand_bypass_mux.sv - combinational per-operand forwarding select
//
// Purpose: picks one source operand from EX result, WB data or register file.
// Ports:
//   src_index                     source register index of the operand
//   rf_data                       register file read data for src_index
//   ex_wr_en/ex_wr_is_load/ex_wr_index/ex_wr_data   EX-stage writer
//   wb_wr_en/wb_wr_index/wb_wr_data                 WB-stage writer
//   operand                       resolved operand value
module operand_bypass_mux #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
) (
    input  logic [IDX_W-1:0]  src_index,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_wr_en,
    input  logic              ex_wr_is_load,
    input  logic [IDX_W-1:0]  ex_wr_index,
    input  logic [DATA_W-1:0] ex_wr_data,
    input  logic              wb_wr_en,
    input  logic [IDX_W-1:0]  wb_wr_index,
    input  logic [DATA_W-1:0] wb_wr_data,
    output logic [DATA_W-1:0] operand
);

    // EX is the youngest writer so it wins; a load in EX has no data yet and
    // is handled by the stall. WB is write-through because the register file
    // only updates at the clock edge. Register 0 is not special.
    always_comb begin
        operand = rf_data;
        if (ex_wr_en && !ex_wr_is_load && (ex_wr_index == src_index)) begin
            operand = ex_wr_data;
        end else if (wb_wr_en && (wb_wr_index == src_index)) begin
            operand = wb_wr_data;
        end
    end

endmodule

// File: rtl/operand_issue_stage.sv
// rtl/operand_issue_stage.sv - decode/operand-fetch stage with forwarding and load-use stall
//
// Purpose: reads the register file, resolves RAW hazards by forwarding from EX
// and WB, stalls one bubble on load-use, and registers the result into ID/EX
// with a valid/ready handshake.
// Optional: define ISSUE_PERF_CNT_EN to add perf_issued/perf_bubbles/perf_flushes.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_valid/if_ready/if_instr/if_pc   fetch handshake and instruction
//   flush                         branch-redirect squash
//   rf_read_index_1/2, rf_read_data_1/2   register file read ports
//   ex_wr_*                       EX-stage destination info
//   wb_wr_*                       WB-stage write port
//   id_valid/id_ready             ID/EX handshake
//   id_opcode/id_rd/id_op_a/id_op_b/id_imm/id_pc   ID/EX payload
module operand_issue_stage #(
    parameter int DATA_W  = pipe_pkg::DATA_W,
    parameter int IDX_W   = pipe_pkg::IDX_W,
    parameter int INSTR_W = pipe_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [DATA_W-1:0]  if_pc,
    input  logic               flush,
    output logic [IDX_W-1:0]   rf_read_index_1,
    output logic [IDX_W-1:0]   rf_read_index_2,
    input  logic [DATA_W-1:0]  rf_read_data_1,
    input  logic [DATA_W-1:0]  rf_read_data_2,
    input  logic               ex_wr_en,
    input  logic               ex_wr_is_load,
    input  logic [IDX_W-1:0]   ex_wr_index,
    input  logic [DATA_W-1:0]  ex_wr_data,
    input  logic               wb_wr_en,
    input  logic [IDX_W-1:0]   wb_wr_index,
    input  logic [DATA_W-1:0]  wb_wr_data,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [5:0]         id_opcode,
    output logic [IDX_W-1:0]   id_rd,
    output logic [DATA_W-1:0]  id_op_a,
    output logic [DATA_W-1:0]  id_op_b,
    output logic [DATA_W-1:0]  id_imm,
    output logic [DATA_W-1:0]  id_pc
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_flushes
`endif
);

    import pipe_pkg::*;

    issue_state_t state;

    logic [IDX_W-1:0]  rs1;
    logic [IDX_W-1:0]  rs2;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              hazard;
    logic              adv;
    logic              accept;
    logic              take_bubble;

    assign rs1 = if_instr[RS1_HI:RS1_LO];
    assign rs2 = if_instr[RS2_HI:RS2_LO];

    assign rf_read_index_1 = rs1;
    assign rf_read_index_2 = rs2;

    // Load data is not available until WB, so a dependent instruction waits.
    assign hazard = if_valid && ex_wr_en && ex_wr_is_load &&
                    ((ex_wr_index == rs1) || (ex_wr_index == rs2));

    assign adv = !id_valid || id_ready;

    assign if_ready    = (state == RUN) && adv && !hazard && !flush;
    assign accept      = if_valid && if_ready;
    assign take_bubble = (state == RUN) && hazard && adv && !flush;

    operand_bypass_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_bypass_a (
        .src_index     (rs1),
        .rf_data       (rf_read_data_1),
        .ex_wr_en      (ex_wr_en),
        .ex_wr_is_load (ex_wr_is_load),
        .ex_wr_index   (ex_wr_index),
        .ex_wr_data    (ex_wr_data),
        .wb_wr_en      (wb_wr_en),
        .wb_wr_index   (wb_wr_index),
        .wb_wr_data    (wb_wr_data),
        .operand       (op_a)
    );

    operand_bypass_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_bypass_b (
        .src_index     (rs2),
        .rf_data       (rf_read_data_2),
        .ex_wr_en      (ex_wr_en),
        .ex_wr_is_load (ex_wr_is_load),
        .ex_wr_index   (ex_wr_index),
        .ex_wr_data    (ex_wr_data),
        .wb_wr_en      (wb_wr_en),
        .wb_wr_index   (wb_wr_index),
        .wb_wr_data    (wb_wr_data),
        .operand       (op_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            id_valid  <= 1'b0;
            id_opcode <= '0;
            id_rd     <= '0;
            id_op_a   <= '0;
            id_op_b   <= '0;
            id_imm    <= '0;
            id_pc     <= '0;
        end else if (flush) begin
            state    <= RUN;
            id_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (take_bubble) begin
                        id_valid <= 1'b0;
                        state    <= BUBBLE;
                    end else if (adv) begin
                        id_valid <= accept;
                        if (accept) begin
                            id_opcode <= if_instr[OPC_HI:OPC_LO];
                            id_rd     <= if_instr[RD_HI:RD_LO];
                            id_op_a   <= op_a;
                            id_op_b   <= op_b;
                            id_imm    <= if_instr[IMM_HI:IMM_LO];
                            id_pc     <= if_pc;
                        end
                    end
                    // !adv: ID/EX holds while EX is stalled
                end
                BUBBLE: begin
                    // The load has moved on to WB; retry the instruction next cycle.
                    id_valid <= 1'b0;
                    state    <= RUN;
                end
                default: begin
                    id_valid <= 1'b0;
                    state    <= RUN;
                end
            endcase
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued  <= '0;
            perf_bubbles <= '0;
            perf_flushes <= '0;
        end else begin
            if (accept)      perf_issued  <= perf_issued + 32'd1;
            if (take_bubble) perf_bubbles <= perf_bubbles + 32'd1;
            if (flush)       perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_issue_stage.sv
// tb/tb_operand_issue_stage.sv - directed self-checking bench for operand_issue_stage
module tb_operand_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        flush;
    logic [4:0]  rf_read_index_1;
    logic [4:0]  rf_read_index_2;
    logic [15:0] rf_read_data_1;
    logic [15:0] rf_read_data_2;
    logic        ex_wr_en;
    logic        ex_wr_is_load;
    logic [4:0]  ex_wr_index;
    logic [15:0] ex_wr_data;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_index;
    logic [15:0] wb_wr_data;
    logic        id_valid;
    logic        id_ready;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [15:0] id_op_a;
    logic [15:0] id_op_b;
    logic [15:0] id_imm;
    logic [15:0] id_pc;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_bubbles;
    logic [31:0] perf_flushes;
`endif

    operand_issue_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .flush           (flush),
        .rf_read_index_1 (rf_read_index_1),
        .rf_read_index_2 (rf_read_index_2),
        .rf_read_data_1  (rf_read_data_1),
        .rf_read_data_2  (rf_read_data_2),
        .ex_wr_en        (ex_wr_en),
        .ex_wr_is_load   (ex_wr_is_load),
        .ex_wr_index     (ex_wr_index),
        .ex_wr_data      (ex_wr_data),
        .wb_wr_en        (wb_wr_en),
        .wb_wr_index     (wb_wr_index),
        .wb_wr_data      (wb_wr_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_opcode       (id_opcode),
        .id_rd           (id_rd),
        .id_op_a         (id_op_a),
        .id_op_b         (id_op_b),
        .id_imm          (id_imm),
        .id_pc           (id_pc)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .perf_issued     (perf_issued),
        .perf_bubbles    (perf_bubbles),
        .perf_flushes    (perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: written at the edge by the WB port
    logic [15:0] regs [32];
    always @(posedge clk) begin
        if (wb_wr_en) regs[wb_wr_index] <= wb_wr_data;
    end
    assign rf_read_data_1 = regs[rf_read_index_1];
    assign rf_read_data_2 = regs[rf_read_index_2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rd,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [10:0] lo);
        return {opc, rd, s1, s2, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_side();
        ex_wr_en = 0; ex_wr_is_load = 0; ex_wr_index = 0; ex_wr_data = 0;
        wb_wr_en = 0; wb_wr_index = 0; wb_wr_data = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 16'h0;
        regs[6] = 16'h0001;
        regs[8] = 16'h0808;
        regs[9] = 16'h9999;
        rst_n = 0; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; id_ready = 1;
        idle_side();
        #12;
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_id_op_a", {16'b0, id_op_a}, 32'd0);
        check("rst_id_pc", {16'b0, id_pc}, 32'd0);
        check("rst_if_ready", {31'b0, if_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1;
        tick();

        // r5 <= 0x1234 via WB
        wb_wr_en = 1; wb_wr_index = 5; wb_wr_data = 16'h1234;
        tick();
        // instr rs1=5 rs2=6
        idle_side();
        if_valid = 1; if_instr = mk(6'h01, 5'd2, 5'd5, 5'd6, 11'h015); if_pc = 16'h0010;
        #1;
        check("basic_if_ready", {31'b0, if_ready}, 32'd1);
        check("basic_rd_idx1", {27'b0, rf_read_index_1}, 32'd5);
        tick();
        check("basic_id_valid", {31'b0, id_valid}, 32'd1);
        check("basic_op_a", {16'b0, id_op_a}, 32'h1234);
        check("basic_op_b", {16'b0, id_op_b}, 32'h0001);
        check("basic_opcode", {26'b0, id_opcode}, 32'h01);
        check("basic_rd", {27'b0, id_rd}, 32'd2);
        check("basic_imm", {16'b0, id_imm}, 32'h3015);
        check("basic_pc", {16'b0, id_pc}, 32'h0010);

        // EX forward beats WB on r3
        ex_wr_en = 1; ex_wr_index = 3; ex_wr_data = 16'hBEEF;
        wb_wr_en = 1; wb_wr_index = 3; wb_wr_data = 16'h1111;
        if_instr = mk(6'h02, 5'd1, 5'd3, 5'd8, 11'h0); if_pc = 16'h0014;
        tick();
        check("exfwd_op_a", {16'b0, id_op_a}, 32'hBEEF);
        check("exfwd_op_b", {16'b0, id_op_b}, 32'h0808);

        // WB write-through on r7; r3 now comes from the register file
        idle_side();
        wb_wr_en = 1; wb_wr_index = 7; wb_wr_data = 16'h00AA;
        if_instr = mk(6'h03, 5'd1, 5'd3, 5'd7, 11'h0); if_pc = 16'h0018;
        tick();
        check("wbfwd_op_a", {16'b0, id_op_a}, 32'h1111);
        check("wbfwd_op_b", {16'b0, id_op_b}, 32'h00AA);

        // Load-use on r4
        idle_side();
        ex_wr_en = 1; ex_wr_is_load = 1; ex_wr_index = 4; ex_wr_data = 16'hDEAD;
        if_instr = mk(6'h01, 5'd2, 5'd4, 5'd0, 11'h0); if_pc = 16'h001C;
        #1;
        check("lu_if_ready_hz", {31'b0, if_ready}, 32'd0);
        tick();
        check("lu_bubble_valid", {31'b0, id_valid}, 32'd0);
        idle_side();
        wb_wr_en = 1; wb_wr_index = 4; wb_wr_data = 16'h5A5A;
        #1;
        check("lu_if_ready_bub", {31'b0, if_ready}, 32'd0);
        tick();
        check("lu_valid_after_bub", {31'b0, id_valid}, 32'd0);
        // r0 forwarded from EX like any register
        ex_wr_en = 1; ex_wr_index = 0; ex_wr_data = 16'h0F0F;
        #1;
        check("lu_if_ready_run", {31'b0, if_ready}, 32'd1);
        tick();
        check("lu_id_valid", {31'b0, id_valid}, 32'd1);
        check("lu_op_a", {16'b0, id_op_a}, 32'h5A5A);
        check("r0_fwd_op_b", {16'b0, id_op_b}, 32'h0F0F);

        // Backpressure for 3 cycles
        idle_side();
        id_ready = 0;
        if_instr = mk(6'h04, 5'd3, 5'd5, 5'd6, 11'h0); if_pc = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_if_ready", {31'b0, if_ready}, 32'd0);
            tick();
            check("bp_id_valid", {31'b0, id_valid}, 32'd1);
            check("bp_id_pc", {16'b0, id_pc}, 32'h001C);
            check("bp_op_a", {16'b0, id_op_a}, 32'h5A5A);
        end
        id_ready = 1;
        #1;
        check("bp_release_ready", {31'b0, if_ready}, 32'd1);
        tick();
        check("bp_next_pc", {16'b0, id_pc}, 32'h0020);
        check("bp_next_op_a", {16'b0, id_op_a}, 32'h1234);

        // Flush during BUBBLE
        ex_wr_en = 1; ex_wr_is_load = 1; ex_wr_index = 9;
        if_instr = mk(6'h10, 5'd4, 5'd9, 5'd0, 11'h0); if_pc = 16'h0024;
        tick();
        idle_side();
        flush = 1;
        #1;
        check("fl_if_ready", {31'b0, if_ready}, 32'd0);
        tick();
        flush = 0;
        check("fl_id_valid", {31'b0, id_valid}, 32'd0);
        #1;
        check("fl_state_run", {31'b0, if_ready}, 32'd1);
`ifdef ISSUE_PERF_CNT_EN
        check("perf_flushes", perf_flushes, 32'd1);
        check("perf_bubbles", perf_bubbles, 32'd2);
`endif
        tick();
        check("fl_reissue_valid", {31'b0, id_valid}, 32'd1);
        check("fl_reissue_op_a", {16'b0, id_op_a}, 32'h9999);
`ifdef ISSUE_PERF_CNT_EN
        check("perf_issued", perf_issued, 32'd6);
`endif
        if_valid = 0;
        tick();
        check("idle_id_valid", {31'b0, id_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
